// File: rtl/vid_timing_pkg.sv
// Shared video timing types and per-mode sizes.
// Used by both the timing generator and the detector.
package vid_timing_pkg;

  typedef enum logic [1:0] {
    RES_640  = 2'd0,
    RES_1080 = 2'd1,
    RES_720  = 2'd2,
    RES_UNK  = 2'd3
  } res_e;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  localparam int H_ACT_640  = 640;
  localparam int V_ACT_640  = 480;
  localparam int H_TOT_640  = 800;
  localparam int V_TOT_640  = 525;

  localparam int H_ACT_1080 = 1920;
  localparam int V_ACT_1080 = 1080;
  localparam int H_TOT_1080 = 2200;
  localparam int V_TOT_1080 = 1125;

  localparam int H_ACT_720  = 1280;
  localparam int V_ACT_720  = 720;
  localparam int H_TOT_720  = 1650;
  localparam int V_TOT_720  = 750;

endpackage

// File: rtl/vid_span_ctr.sv
// Saturating span counter; held captures the count
// including the current cycle's increment.
module vid_span_ctr #(
  parameter int W = 12
) (
  input  logic         clk_pix,
  input  logic         rst_pix_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         lat,
  output logic [W-1:0] cnt,
  output logic [W-1:0] held
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] nxt;

  assign nxt = (inc && cnt != MAX) ? cnt + 1'b1 : cnt;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      cnt  <= '0;
      held <= '0;
    end else begin
      if (lat) held <= nxt;
      cnt <= clr ? '0 : nxt;
    end
  end

endmodule

// File: rtl/vid_timing_det.sv
// Incoming video timing detector: coordinates,
// size measurement, lock tracking and mode code.
module vid_timing_det
  import vid_timing_pkg::*;
#(
  parameter int W           = 12,
  parameter int LOCK_FRAMES = 3,
  parameter int WDOG_CYCLES = 4095
) (
  input  logic         clk_pix,
  input  logic         rst_pix_n,
  input  logic         hsync_i,
  input  logic         vsync_i,
  input  logic         de_i,
  output logic         de_o,
  output logic [W-1:0] sx,
  output logic [W-1:0] sy,
  output logic [W-1:0] h_act,
  output logic [W-1:0] v_act,
  output logic [W-1:0] h_tot,
  output logic [W-1:0] v_tot,
  output logic         frame_done,
  output logic         locked,
  output logic [1:0]   res,
  output logic         res_valid,
  output logic         timing_err
);

  localparam int CW = $clog2(LOCK_FRAMES + 1);

  logic hsync_q, vsync_q, de_q, frame_start;
  logic hs_fall, vs_fall, de_rise, de_fall;

  assign hs_fall = hsync_q & ~hsync_i;
  assign vs_fall = vsync_q & ~vsync_i;
  assign de_rise = ~de_q & de_i;
  assign de_fall = de_q & ~de_i;
  assign de_o    = de_q;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      de_q        <= 1'b0;
      frame_start <= 1'b1;
      sx          <= '0;
      sy          <= '0;
    end else begin
      hsync_q <= hsync_i;
      vsync_q <= vsync_i;
      de_q    <= de_i;
      if (de_rise) begin
        sx <= '0;
        sy <= frame_start ? '0 : sy + 1'b1;
      end else if (de_i) begin
        sx <= sx + 1'b1;
      end
      if (vs_fall)      frame_start <= 1'b1;
      else if (de_rise) frame_start <= 1'b0;
    end
  end

  logic [W-1:0] hcyc_cnt, hcyc_lat;
  logic [W-1:0] hact_cnt, hact_lat;
  logic [W-1:0] lines_cnt, vlines_cnt;

  vid_span_ctr #(.W(W)) u_hcyc (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .clr       (hs_fall),
    .inc       (1'b1),
    .lat       (hs_fall),
    .cnt       (hcyc_cnt),
    .held      (hcyc_lat)
  );

  vid_span_ctr #(.W(W)) u_hact (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .clr       (~de_i),
    .inc       (de_i),
    .lat       (de_fall),
    .cnt       (hact_cnt),
    .held      (hact_lat)
  );

  // held includes a coincident hs_fall before the clear
  vid_span_ctr #(.W(W)) u_lines (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .clr       (vs_fall),
    .inc       (hs_fall),
    .lat       (vs_fall),
    .cnt       (lines_cnt),
    .held      (v_tot)
  );

  vid_span_ctr #(.W(W)) u_vlines (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .clr       (vs_fall),
    .inc       (de_rise),
    .lat       (vs_fall),
    .cnt       (vlines_cnt),
    .held      (v_act)
  );

  logic unused_ok;
  assign unused_ok = ^{hact_cnt, lines_cnt, vlines_cnt};

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      h_tot      <= '0;
      h_act      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= vs_fall;
      if (vs_fall) begin
        h_tot <= hcyc_lat;
        h_act <= hact_lat;
      end
    end
  end

  logic [4*W-1:0] tup, prev_tup;
  logic           prev_ok, match, wdog;
  lock_state_e    state, state_nxt;
  logic [CW-1:0]  mcnt, mcnt_nxt;
  res_e           res_q, res_cls;

  assign tup   = {h_act, v_act, h_tot, v_tot};
  assign match = prev_ok && (tup == prev_tup);
  assign wdog  = ~hs_fall &&
                 (hcyc_cnt == W'(WDOG_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    mcnt_nxt  = mcnt;
    if (wdog) begin
      state_nxt = ST_UNLOCKED;
      mcnt_nxt  = '0;
    end else if (frame_done) begin
      unique case (state)
        ST_UNLOCKED: begin
          if (match) begin
            mcnt_nxt = mcnt + 1'b1;
            if (mcnt_nxt == CW'(LOCK_FRAMES - 1))
              state_nxt = ST_LOCKED;
          end else begin
            mcnt_nxt = '0;
          end
        end
        ST_LOCKED: begin
          if (!match) begin
            state_nxt = ST_UNLOCKED;
            mcnt_nxt  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    res_cls = RES_UNK;
    unique case (1'b1)
      (h_act == W'(H_ACT_640)  && v_act == W'(V_ACT_640) &&
       h_tot == W'(H_TOT_640)  && v_tot == W'(V_TOT_640)):
        res_cls = RES_640;
      (h_act == W'(H_ACT_1080) && v_act == W'(V_ACT_1080) &&
       h_tot == W'(H_TOT_1080) && v_tot == W'(V_TOT_1080)):
        res_cls = RES_1080;
      (h_act == W'(H_ACT_720)  && v_act == W'(V_ACT_720) &&
       h_tot == W'(H_TOT_720)  && v_tot == W'(V_TOT_720)):
        res_cls = RES_720;
      default:
        res_cls = RES_UNK;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state      <= ST_UNLOCKED;
      mcnt       <= '0;
      prev_tup   <= '0;
      prev_ok    <= 1'b0;
      timing_err <= 1'b0;
      res_q      <= RES_UNK;
    end else begin
      state      <= state_nxt;
      mcnt       <= mcnt_nxt;
      timing_err <= (state == ST_LOCKED) &&
                    (state_nxt == ST_UNLOCKED);
      if (frame_done) begin
        prev_tup <= tup;
        prev_ok  <= 1'b1;
      end
      if (state_nxt != ST_LOCKED) res_q <= RES_UNK;
      else if (frame_done)        res_q <= res_cls;
    end
  end

  assign locked    = (state == ST_LOCKED);
  assign res       = res_q;
  assign res_valid = locked && (res_q != RES_UNK);

endmodule
